mult_arbiter: RTL

Round-robin arbiter and sequencer that shares one combinational 8x8 `array_multiplier` among `NREQ` requesters. Each requester presents operands over a valid/ready handshake. The block registers the winning operands, gives the multiplier one full cycle to settle, and returns the 16-bit product tagged with the requester index on a single response channel with backpressure. It sits between operand producers and the shared multiplier datapath.

---
 rtl/mult_pkg.sv | 13 +
 rtl/array_multiplier.sv | 19 +
 rtl/rr_pick.sv | 34 +++
 rtl/mult_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared widths and FSM encoding for the multiplier arbiter.
package mult_pkg;

  localparam int unsigned MUL_W  = 8;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/array_multiplier.sv
// Combinational unsigned 8x8 shift-and-add array multiplier.
module array_multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] sum
);

  logic [15:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc + (16'(a) << i);
    end
  end

  assign sum = acc;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  always_comb begin
    int              idx;
    logic [IDW-1:0]  sel;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    sel     = '0;
    // Walk from the farthest candidate back to ptr so the nearest hit wins.
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      sel = IDW'(idx);
      if (req[sel]) begin
        gnt     = NREQ'(1) << sel;
        gnt_idx = sel;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sequencer sharing one combinational 8x8 multiplier among NREQ requesters.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*MUL_W-1:0]  req_a,
  input  logic [NREQ*MUL_W-1:0]  req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [PROD_W-1:0]      resp_prod,
  output logic [IDW-1:0]         resp_id,
  output logic                   busy
);

  state_t              state;
  logic [IDW-1:0]      ptr;
  logic [MUL_W-1:0]    op_a;
  logic [MUL_W-1:0]    op_b;
  logic [IDW-1:0]      op_id;
  logic [PROD_W-1:0]   mul_sum;

  logic                resp_hs;
  logic                grant_ok;
  logic [IDW-1:0]      ptr_wrap;
  logic [IDW-1:0]      pick_ptr;
  logic [NREQ-1:0]     gnt;
  logic [IDW-1:0]      gnt_idx;
  logic                any;
  logic [MUL_W-1:0]    sel_a;
  logic [MUL_W-1:0]    sel_b;

  // The pointer update on a response handshake is visible to the same-cycle grant.
  assign resp_hs   = (state == RESP) && resp_ready;
  assign grant_ok  = (state == IDLE) || resp_hs;
  assign ptr_wrap  = (resp_id == IDW'(NREQ - 1)) ? '0 : resp_id + IDW'(1);
  assign pick_ptr  = resp_hs ? ptr_wrap : ptr;
  assign req_ready = grant_ok ? gnt : '0;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req     (req_valid),
    .ptr     (pick_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a = req_a[i*MUL_W +: MUL_W];
        sel_b = req_b[i*MUL_W +: MUL_W];
      end
    end
  end

  array_multiplier u_mul (
    .a   (op_a),
    .b   (op_b),
    .sum (mul_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= '0;
      resp_valid <= 1'b0;
      resp_prod  <= '0;
      resp_id    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            op_a  <= sel_a;
            op_b  <= sel_b;
            op_id <= gnt_idx;
            state <= MUL;
            busy  <= 1'b1;
          end
        end
        MUL: begin
          resp_prod  <= mul_sum;
          resp_id    <= op_id;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            ptr        <= ptr_wrap;
            if (any) begin
              op_a  <= sel_a;
              op_b  <= sel_b;
              op_id <= gnt_idx;
              state <= MUL;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
